// File: rtl/axi_hp_stream_writer_if.sv
// AXI3 write-only channel bundle (AW/W/B) for one Zynq HP slave port.
// Valid/ready contract: a beat transfers on the rising edge where valid and ready are both high;
// the source keeps valid and its payload stable until that edge, and ready may change freely.
interface axi_hp_stream_writer_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic [5:0]          awid;
  logic [1:0]          awlock;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [5:0]          wid;
  logic                wvalid;
  logic                wlast;
  logic                wready;
  logic [5:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awid, awlock, awprot, awqos, awvalid,
    output wdata, wstrb, wid, wvalid, wlast, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awid, awlock, awprot, awqos, awvalid,
    input  wdata, wstrb, wid, wvalid, wlast, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_hp_stream_writer.sv
// Stream-to-DDR capture engine: samples are queued in a FIFO and written as fixed INCR bursts
// into a circular buffer, one burst in flight at a time (AW, then W beats, then B).
module axi_hp_stream_writer #(
  parameter int          DATA_W     = 32,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [5:0]  AXI_ID     = 6'd0
) (
  input  logic                          AXI_clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   base_addr,
  input  logic [31:0]                   buf_size,
  input  logic [DATA_W-1:0]             Sin,
  input  logic                          Ien,
  output logic                          overflow,
  output logic                          resp_err,
  output logic [31:0]                   wr_ptr,
  output logic [31:0]                   burst_cnt,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
  axi_hp_stream_writer_if.master        axi
);
  localparam int          AW_W        = $clog2(FIFO_DEPTH);
  localparam int          CW          = AW_W + 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * DATA_W / 8);
  localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_W = 2'd2, S_B = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW_W-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        beat_q, beat_d;
  logic [31:0]       awaddr_q, awaddr_d, size_q, size_d;
  logic [31:0]       wr_ptr_q, wr_ptr_d, burst_cnt_q, burst_cnt_d, next_ptr;
  logic              overflow_q, overflow_d, resp_err_q, resp_err_d, enable_q;
  logic              full, push, pop, flush;
  logic              unused_bid;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign push       = enable & Ien & ~full;
  assign pop        = (state_q == S_W) & axi.wready;
  assign next_ptr   = wr_ptr_q + BURST_BYTES;
  assign unused_bid = ^axi.bid;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    awaddr_d    = awaddr_q;
    size_d      = size_q;
    wr_ptr_d    = wr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    overflow_d  = overflow_q;
    resp_err_d  = resp_err_q;
    flush       = 1'b0;

    // Re-arming capture clears the sticky flags; a new event in the same cycle still sets them.
    if (enable && !enable_q) begin
      overflow_d = 1'b0;
      resp_err_d = 1'b0;
    end
    if (enable && Ien && full) overflow_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!enable) begin
          flush    = 1'b1;
          wr_ptr_d = 32'd0;
        end else if (count_q >= CW'(BURST_LEN)) begin
          state_d  = S_AW;
          awaddr_d = base_addr + wr_ptr_q;
          size_d   = buf_size;
          beat_d   = 4'd0;
        end
      end
      S_AW: if (axi.awready) state_d = S_W;
      S_W: begin
        if (axi.wready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) state_d = S_B;
        end
      end
      S_B: begin
        if (axi.bvalid) begin
          wr_ptr_d    = (next_ptr >= size_q) ? 32'd0 : next_ptr;
          burst_cnt_d = burst_cnt_q + 32'd1;
          if (axi.bresp != 2'b00) resp_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_idx_d = wr_idx_q + AW_W'(push);
    rd_idx_d = rd_idx_q + AW_W'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Flushing only happens in IDLE with enable low, so no push or pop competes with it.
    if (flush) begin
      rd_idx_d = wr_idx_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      beat_q      <= 4'd0;
      awaddr_q    <= 32'd0;
      size_q      <= 32'd0;
      wr_ptr_q    <= 32'd0;
      burst_cnt_q <= 32'd0;
      overflow_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      awaddr_q    <= awaddr_d;
      size_q      <= size_d;
      wr_ptr_q    <= wr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      overflow_q  <= overflow_d;
      resp_err_q  <= resp_err_d;
      enable_q    <= enable;
    end
  end

  always_ff @(posedge AXI_clk) begin
    if (push) mem_q[wr_idx_q] <= Sin;
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = LAST_BEAT;
  assign axi.awsize  = (DATA_W == 64) ? 3'd3 : 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awcache = 4'b0011;
  assign axi.awid    = AXI_ID;
  assign axi.awlock  = 2'b00;
  assign axi.awprot  = 3'b000;
  assign axi.awqos   = 4'b0000;
  assign axi.awvalid = (state_q == S_AW);
  assign axi.wdata   = mem_q[rd_idx_q];
  assign axi.wstrb   = '1;
  assign axi.wid     = AXI_ID;
  assign axi.wvalid  = (state_q == S_W);
  assign axi.wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
  assign axi.bready  = (state_q == S_B);

  assign overflow  = overflow_q;
  assign resp_err  = resp_err_q;
  assign wr_ptr    = wr_ptr_q;
  assign burst_cnt = burst_cnt_q;
  assign dbg_state = state_q;
  assign dbg_count = count_q;
endmodule

// File: tb/tb_axi_hp_stream_writer.sv
// Directed bench for axi_hp_stream_writer: a slave responder records every AW/W/B handshake and the
// main sequence compares them against hand-computed addresses, sample values and status flags.
module tb_axi_hp_stream_writer;
  logic        clk = 1'b0;
  logic        rst, enable, Ien;
  logic [31:0] base_addr, buf_size, Sin;
  logic        overflow, resp_err;
  logic [31:0] wr_ptr, burst_cnt;
  logic [1:0]  dbg_state;
  logic [6:0]  dbg_count;

  logic        aw_rdy_en = 1'b1, w_rdy_en = 1'b1, w_toggle = 1'b0, tog = 1'b0;
  int          err_idx = -1;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic        wl_q[$];
  int          b_count = 0, w_stall_err = 0;
  int          aw_rd = 0, w_rd = 0;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  axi_hp_stream_writer_if #(.DATA_W(32)) AXI ();

  axi_hp_stream_writer #(.DATA_W(32), .BURST_LEN(16), .FIFO_DEPTH(64), .AXI_ID(6'd0)) dut (
    .AXI_clk(clk), .rst(rst), .enable(enable), .base_addr(base_addr), .buf_size(buf_size),
    .Sin(Sin), .Ien(Ien), .overflow(overflow), .resp_err(resp_err), .wr_ptr(wr_ptr),
    .burst_cnt(burst_cnt), .dbg_state(dbg_state), .dbg_count(dbg_count), .axi(AXI.master)
  );

  assign AXI.awready = aw_rdy_en;
  assign AXI.wready  = w_rdy_en & (~w_toggle | tog);

  // Slave responder: observe at negedge, drive just after posedge.
  initial begin : slave
    logic        aw_f, w_f, wl_f, b_f, stalled;
    logic [31:0] stall_data;
    AXI.bvalid = 1'b0;
    AXI.bresp  = 2'b00;
    AXI.bid    = 6'd0;
    stalled    = 1'b0;
    stall_data = 32'd0;
    forever begin
      @(negedge clk);
      aw_f = AXI.awvalid & AXI.awready;
      w_f  = AXI.wvalid & AXI.wready;
      wl_f = w_f & AXI.wlast;
      b_f  = AXI.bvalid & AXI.bready;
      if (aw_f) aw_q.push_back(AXI.awaddr);
      if (w_f) begin
        w_q.push_back(AXI.wdata);
        wl_q.push_back(AXI.wlast);
      end
      if (stalled && AXI.wvalid && (AXI.wdata !== stall_data)) w_stall_err++;
      stalled    = AXI.wvalid & ~AXI.wready;
      stall_data = AXI.wdata;
      if (b_f) b_count++;
      @(posedge clk);
      #1;
      tog = ~tog;
      if (b_f || rst) AXI.bvalid = 1'b0;
      if (wl_f) begin
        AXI.bvalid = 1'b1;
        AXI.bresp  = (b_count == err_idx) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      Ien = 1'b1;
      Sin = first + 32'(i);
      tick();
    end
    Ien = 1'b0;
  endtask

  task automatic wait_bcnt(input string tag, input int target);
    int n = 0;
    while (b_count < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 64'(b_count), 64'(target));
  endtask

  task automatic wait_awvalid(input string tag);
    int n = 0;
    while (!AXI.awvalid && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(AXI.awvalid), 64'd1);
  endtask

  task automatic check_aw(input string tag, input logic [31:0] addr);
    check(tag, 64'(aw_q[aw_rd]), 64'(addr));
    aw_rd++;
  endtask

  task automatic check_beats(input string tag, input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      check({tag, "_wdata"}, 64'(w_q[w_rd + i]), 64'(first + 32'(i)));
      check({tag, "_wlast"}, 64'(wl_q[w_rd + i]), 64'((i % 16) == 15));
    end
    w_rd += n;
    check({tag, "_beat_count"}, 64'(w_q.size()), 64'(w_rd));
  endtask

  initial begin : main
    logic [31:0] held_addr;
    logic        stable;
    rst = 1'b1; enable = 1'b0; Ien = 1'b0; Sin = 32'd0;
    base_addr = 32'h1000_0000; buf_size = 32'h100;
    repeat (3) tick();
    check("rst_awvalid", 64'(AXI.awvalid), 64'd0);
    check("rst_wvalid", 64'(AXI.wvalid), 64'd0);
    check("rst_bready", 64'(AXI.bready), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("rst_burst_cnt", 64'(burst_cnt), 64'd0);
    check("rst_count", 64'(dbg_count), 64'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // 64 samples -> four bursts around a 0x100 ring.
    send(64, 32'hA000_0000);
    wait_bcnt("t1_bursts", 4);
    check_aw("t1_aw0", 32'h1000_0000);
    check_aw("t1_aw1", 32'h1000_0040);
    check_aw("t1_aw2", 32'h1000_0080);
    check_aw("t1_aw3", 32'h1000_00C0);
    check_beats("t1", 64, 32'hA000_0000);
    check("t1_wr_ptr", 64'(wr_ptr), 64'd0);
    check("t1_burst_cnt", 64'(burst_cnt), 64'd4);

    // Samples 64..79 land at the ring base again.
    send(16, 32'hA000_0040);
    wait_bcnt("t2_bursts", 5);
    check_aw("t2_aw_wrap", 32'h1000_0000);
    check_beats("t2", 16, 32'hA000_0040);
    check("t2_wr_ptr", 64'(wr_ptr), 64'h40);
    check("t2_burst_cnt", 64'(burst_cnt), 64'd5);

    // AW stalled 20 cycles, W ready toggling.
    aw_rdy_en = 1'b0;
    w_toggle  = 1'b1;
    send(16, 32'hA000_0050);
    wait_awvalid("t3_awvalid");
    held_addr = AXI.awaddr;
    check("t3_awaddr", 64'(held_addr), 64'h1000_0040);
    check("t3_awlen", 64'(AXI.awlen), 64'd15);
    check("t3_awsize", 64'(AXI.awsize), 64'd2);
    check("t3_awburst", 64'(AXI.awburst), 64'd1);
    check("t3_awcache", 64'(AXI.awcache), 64'd3);
    check("t3_awid", 64'(AXI.awid), 64'd0);
    check("t3_wstrb", 64'(AXI.wstrb), 64'hF);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(AXI.awvalid === 1'b1 && AXI.awaddr === held_addr)) stable = 1'b0;
    end
    check("t3_aw_stable", 64'(stable), 64'd1);
    aw_rdy_en = 1'b1;
    wait_bcnt("t3_bursts", 6);
    w_toggle = 1'b0;
    check_aw("t3_aw", 32'h1000_0040);
    check_beats("t3", 16, 32'hA000_0050);
    check("t3_wdata_stall", 64'(w_stall_err), 64'd0);
    check("t3_wr_ptr", 64'(wr_ptr), 64'h80);

    // Overflow: 100 samples with W blocked; only the first 64 survive.
    w_rdy_en = 1'b0;
    send(64, 32'hB000_0000);
    check("t4_no_overflow_yet", 64'(overflow), 64'd0);
    send(1, 32'hB000_0040);
    check("t4_overflow", 64'(overflow), 64'd1);
    send(35, 32'hB000_0041);
    check("t4_fifo_full", 64'(dbg_count), 64'd64);
    w_rdy_en = 1'b1;
    wait_bcnt("t4_bursts", 10);
    check_aw("t4_aw0", 32'h1000_0080);
    check_aw("t4_aw1", 32'h1000_00C0);
    check_aw("t4_aw2", 32'h1000_0000);
    check_aw("t4_aw3", 32'h1000_0040);
    check_beats("t4", 64, 32'hB000_0000);
    check("t4_overflow_sticky", 64'(overflow), 64'd1);

    // Re-arm, then a SLVERR on the second burst.
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    check("t5_overflow_cleared", 64'(overflow), 64'd0);
    check("t5_wr_ptr_reset", 64'(wr_ptr), 64'd0);
    err_idx = 11;
    send(32, 32'hC000_0000);
    wait_bcnt("t5_burst1", 11);
    check("t5_resp_ok", 64'(resp_err), 64'd0);
    check("t5_wr_ptr1", 64'(wr_ptr), 64'h40);
    wait_bcnt("t5_burst2", 12);
    check("t5_resp_err", 64'(resp_err), 64'd1);
    check("t5_wr_ptr2", 64'(wr_ptr), 64'h80);
    err_idx = -1;
    enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    check("t5_resp_err_cleared", 64'(resp_err), 64'd0);
    check("t5_burst_cnt_kept", 64'(burst_cnt), 64'd12);
    check_aw("t5_aw0", 32'h1000_0000);
    check_aw("t5_aw1", 32'h1000_0040);
    check_beats("t5", 32, 32'hC000_0000);

    // Disable mid-W with 10 extra samples queued: burst completes, remainder flushed.
    send(26, 32'hD000_0000);
    check("t6_in_w", 64'(dbg_state), 64'd2);
    enable = 1'b0;
    wait_bcnt("t6_burst", 13);
    repeat (3) tick();
    check("t6_flushed", 64'(dbg_count), 64'd0);
    check("t6_wr_ptr", 64'(wr_ptr), 64'd0);
    check("t6_idle", 64'(dbg_state), 64'd0);
    check("t6_aw_total", 64'(aw_q.size()), 64'd13);
    check_aw("t6_aw", 32'h1000_0000);
    check_beats("t6", 16, 32'hD000_0000);

    // Reset while AW is pending drops awvalid on the next cycle.
    enable = 1'b1;
    aw_rdy_en = 1'b0;
    tick();
    send(16, 32'hE000_0000);
    wait_awvalid("t6_aw_pending");
    rst = 1'b1;
    tick();
    check("t6_rst_awvalid", 64'(AXI.awvalid), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'd0);
    check("t6_rst_count", 64'(dbg_count), 64'd0);
    check("t6_rst_burst_cnt", 64'(burst_cnt), 64'd0);
    rst = 1'b0;
    aw_rdy_en = 1'b1;
    repeat (5) tick();
    check("t6_post_rst_quiet", 64'(AXI.awvalid), 64'd0);
    check("t6_no_extra_aw", 64'(aw_q.size()), 64'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
